cmp_share_arb: RTL

- Two-requester arbiter and sequencer for one shared 32-bit branch comparator.
- Sits between the branch-resolution paths, e.g. the ID-stage early branch and the EX-stage branch/slt path, and a single compare datapath.
- Each requester issues a valid/ready transaction carrying {a, b, ctrl, tag}. The block picks one per cycle round-robin, evaluates the compare, and returns a registered 1-bit result with the requester id and tag.
- The result is held under back-pressure until the consumer accepts it.

---
 rtl/cmp_share_arb.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/cmp_share_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cmp_share_arb
//
// Shares one 32-bit branch comparator between two requesters (for example the
// ID-stage early-branch path and the EX-stage branch/slt path). The block picks
// one pending request per cycle round-robin and evaluates the compare. The
// 1-bit outcome, the requester id and the echoed tag go into a result register,
// which holds them until the consumer accepts.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   reqN_valid / reqN_ready  request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b         32-bit operands
//   reqN_ctrl              compare op:
//                            000 EQ, 001 NE, 100 LT, 101 GE,
//                            110 LTU, 111 GEU; 010/011 illegal -> 0
//   reqN_tag               opaque tag, echoed on resp_tag
//   resp_valid/resp_ready  result handshake
//   resp_c                 compare outcome
//   resp_id                requester that issued the result
//   resp_tag               tag of that request
//   resp_err               (only with CMP_SHARE_ARB_ERR_EN) set when the
//                          accepted ctrl was an illegal code
//
// Build option
//   CMP_SHARE_ARB_ERR_EN   adds the resp_err output
//
// state   | meaning
// --------+-------------------------------------------
// S_EMPTY | result register free, resp_valid = 0
// S_FULL  | result register holds an unconsumed result
// -----------------------------------------------------------------------------
module cmp_share_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [2:0]       req0_ctrl,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [2:0]       req1_ctrl,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_c,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag
`ifdef CMP_SHARE_ARB_ERR_EN
    ,
    output logic             resp_err
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             state;
    logic               last_grant;

    logic               grant;
    logic               slot_open;
    logic               hs0;
    logic               hs1;
    logic               hs_any;

    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [2:0]         sel_ctrl;
    logic [TAG_W-1:0]   sel_tag;

    logic               cmp_eq;
    logic               cmp_lt_s;
    logic               cmp_lt_u;
    logic               cmp_res;
    logic               cmp_illegal;

    // Grant depends only on the valids and the round-robin register, so a
    // requester never has to see ready before it raises valid.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // A full register can take a new result in the same cycle that the
    // consumer drains the old one, which gives back-to-back throughput.
    assign slot_open = (state == S_EMPTY) || resp_ready;

    // Gating with rst_n keeps both readies low for the whole reset, even
    // though the state register already reads S_EMPTY.
    assign req0_ready = rst_n && slot_open && req0_valid && !grant;
    assign req1_ready = rst_n && slot_open && req1_valid &&  grant;

    assign hs0    = req0_valid && req0_ready;
    assign hs1    = req1_valid && req1_ready;
    assign hs_any = hs0 || hs1;

    always_comb begin
        if (grant) begin
            sel_a    = req1_a;
            sel_b    = req1_b;
            sel_ctrl = req1_ctrl;
            sel_tag  = req1_tag;
        end else begin
            sel_a    = req0_a;
            sel_b    = req0_b;
            sel_ctrl = req0_ctrl;
            sel_tag  = req0_tag;
        end
    end

    assign cmp_eq      = (sel_a == sel_b);
    assign cmp_lt_u    = (sel_a < sel_b);
    assign cmp_lt_s    = ($signed(sel_a) < $signed(sel_b));
    assign cmp_illegal = (sel_ctrl[2:1] == 2'b01);

    always_comb begin
        cmp_res = 1'b0;
        case (sel_ctrl)
            3'b000:  cmp_res = cmp_eq;
            3'b001:  cmp_res = ~cmp_eq;
            3'b100:  cmp_res = cmp_lt_s;
            3'b101:  cmp_res = ~cmp_lt_s;
            3'b110:  cmp_res = cmp_lt_u;
            3'b111:  cmp_res = ~cmp_lt_u;
            default: cmp_res = 1'b0;
        endcase
    end

    // Result FSM and round-robin pointer. last_grant moves only on a real
    // handshake, so a requester that is granted but blocked keeps its turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_EMPTY;
            last_grant <= 1'b1;
            resp_c     <= 1'b0;
            resp_id    <= 1'b0;
            resp_tag   <= '0;
`ifdef CMP_SHARE_ARB_ERR_EN
            resp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_EMPTY: begin
                    if (hs_any) begin
                        state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (!hs_any && resp_ready) begin
                        state <= S_EMPTY;
                    end
                end
                default: state <= S_EMPTY;
            endcase

            if (hs_any) begin
                last_grant <= grant;
                resp_c     <= cmp_res;
                resp_id    <= grant;
                resp_tag   <= sel_tag;
`ifdef CMP_SHARE_ARB_ERR_EN
                resp_err   <= cmp_illegal;
`endif
            end
        end
    end

    assign resp_valid = (state == S_FULL);

`ifndef CMP_SHARE_ARB_ERR_EN
    // The illegal-code flag only reaches a port in the error-reporting
    // build; this keeps the net referenced in the default build.
    logic unused_illegal;
    assign unused_illegal = cmp_illegal;
`endif

endmodule
